// File: rtl/vx_mem_line_serializer.sv
// Line-to-beat memory request serializer with beat-to-line read response assembly.
// Sits between a cache memory port (line wide) and a narrower memory bus (beat wide).
module vx_mem_line_serializer #(
    parameter int LINE_SIZE  = 64,
    parameter int BEAT_SIZE  = 16,
    parameter int ADDR_WIDTH = 26,
    parameter int TAG_WIDTH  = 8,
    parameter bit SKIP_EMPTY = 1'b1,
    localparam int RATIO     = LINE_SIZE / BEAT_SIZE,
    localparam int LOG_R     = $clog2(RATIO)
) (
    input  logic                         clk,
    input  logic                         reset,

    input  logic                         in_req_valid,
    input  logic                         in_req_rw,
    input  logic [ADDR_WIDTH-1:0]        in_req_addr,
    input  logic [LINE_SIZE-1:0]         in_req_byteen,
    input  logic [LINE_SIZE*8-1:0]       in_req_data,
    input  logic [TAG_WIDTH-1:0]         in_req_tag,
    output logic                         in_req_ready,

    output logic                         in_rsp_valid,
    output logic [LINE_SIZE*8-1:0]       in_rsp_data,
    output logic [TAG_WIDTH-1:0]         in_rsp_tag,
    input  logic                         in_rsp_ready,

    output logic                         out_req_valid,
    output logic                         out_req_rw,
    output logic [ADDR_WIDTH+LOG_R-1:0]  out_req_addr,
    output logic [BEAT_SIZE-1:0]         out_req_byteen,
    output logic [BEAT_SIZE*8-1:0]       out_req_data,
    output logic [TAG_WIDTH+LOG_R-1:0]   out_req_tag,
    input  logic                         out_req_ready,

    input  logic                         out_rsp_valid,
    input  logic [BEAT_SIZE*8-1:0]       out_rsp_data,
    input  logic [TAG_WIDTH+LOG_R-1:0]   out_rsp_tag,
    output logic                         out_rsp_ready
);

    typedef logic [LOG_R-1:0]                  idx_t;
    typedef logic [RATIO-1:0][BEAT_SIZE-1:0]   line_be_t;
    typedef logic [RATIO-1:0][BEAT_SIZE*8-1:0] line_data_t;
    typedef enum logic {ST_IDLE, ST_SEND} state_e;

    if (RATIO < 2 || (LINE_SIZE % BEAT_SIZE) != 0 || (RATIO & (RATIO - 1)) != 0) begin : g_param_check
        $error("vx_mem_line_serializer: LINE_SIZE/BEAT_SIZE must be a power of two >= 2");
    end

    // Beats that must be issued: all beats for reads, non-empty beats for writes when skipping.
    function automatic logic [RATIO-1:0] issue_mask(input logic rw, input line_be_t be);
        logic [RATIO-1:0] m;
        for (int i = 0; i < RATIO; i++) begin
            m[i] = !(SKIP_EMPTY && rw) || (|be[i]);
        end
        return m;
    endfunction

    // Lowest set position of mask at or above lo; MSB of the result is the found flag.
    function automatic logic [LOG_R:0] find_beat(input logic [RATIO-1:0] mask, input int lo);
        logic [LOG_R:0] r;
        r = '0;
        for (int i = RATIO - 1; i >= 0; i--) begin
            if (mask[i] && i >= lo) r = {1'b1, idx_t'(i)};
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Request path
    // ------------------------------------------------------------------
    state_e            state_q, state_d;
    idx_t              beat_idx_q, beat_idx_d;
    logic              out_req_valid_q, out_req_valid_d;
    logic              rw_q, rw_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    line_be_t          byteen_q, byteen_d;
    line_data_t        data_q, data_d;
    logic [TAG_WIDTH-1:0]  tag_q, tag_d;
    logic [LOG_R:0]    first_hit, next_hit;
    logic              req_fire;

    assign in_req_ready   = (state_q == ST_IDLE);
    // A beat still registered as valid must not be offered while reset is asserted.
    assign out_req_valid  = out_req_valid_q && !reset;
    assign req_fire       = out_req_valid && out_req_ready;
    assign out_req_rw     = rw_q;
    assign out_req_addr   = {addr_q, beat_idx_q};
    assign out_req_byteen = rw_q ? byteen_q[beat_idx_q] : {BEAT_SIZE{1'b1}};
    assign out_req_data   = data_q[beat_idx_q];
    assign out_req_tag    = {tag_q, beat_idx_q};

    // Next-state for the line capture / beat issue FSM.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
        state_d         = state_q;
        beat_idx_d      = beat_idx_q;
        out_req_valid_d = out_req_valid_q;
        rw_d            = rw_q;
        addr_d          = addr_q;
        byteen_d        = byteen_q;
        data_d          = data_q;
        tag_d           = tag_q;
        first_hit       = find_beat(issue_mask(in_req_rw, line_be_t'(in_req_byteen)), 0);
        next_hit        = find_beat(issue_mask(rw_q, byteen_q), int'(beat_idx_q) + 1);

        case (state_q)
            ST_IDLE: begin
                if (in_req_valid) begin
                    rw_d     = in_req_rw;
                    addr_d   = in_req_addr;
                    byteen_d = line_be_t'(in_req_byteen);
                    data_d   = line_data_t'(in_req_data);
                    tag_d    = in_req_tag;
                    // An all-empty write is swallowed here and the FSM stays idle.
                    if (first_hit[LOG_R]) begin
                        state_d         = ST_SEND;
                        beat_idx_d      = first_hit[LOG_R-1:0];
                        out_req_valid_d = 1'b1;
                    end
                end
            end
            ST_SEND: begin
                if (req_fire) begin
                    if (next_hit[LOG_R]) begin
                        beat_idx_d = next_hit[LOG_R-1:0];
                    end else begin
                        state_d         = ST_IDLE;
                        beat_idx_d      = '0;
                        out_req_valid_d = 1'b0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control state of the request FSM.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values.
        if (reset) begin
            state_q         <= ST_IDLE;
            beat_idx_q      <= '0;
            out_req_valid_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            beat_idx_q      <= beat_idx_d;
            out_req_valid_q <= out_req_valid_d;
        end
    end

    // Captured line request payload.
    always_ff @(posedge clk) begin
        // NOTE: payload storage has no reset; it is only observed while the FSM marks it valid.
        rw_q     <= rw_d;
        addr_q   <= addr_d;
        byteen_q <= byteen_d;
        data_q   <= data_d;
        tag_q    <= tag_d;
    end

    // ------------------------------------------------------------------
    // Response path
    // ------------------------------------------------------------------
    line_data_t           rsp_buf_q, rsp_buf_d;
    idx_t                 rsp_cnt_q, rsp_cnt_d;
    logic                 rsp_full_q, rsp_full_d;
    logic [TAG_WIDTH-1:0] rsp_tag_q, rsp_tag_d;
    logic                 beat_fire;
    idx_t                 rsp_idx;
    logic [TAG_WIDTH-1:0] rsp_utag;

    // The buffer frees in the same cycle the cache takes the line, so a new beat can land then.
    assign out_rsp_ready = !rsp_full_q || in_rsp_ready;
    assign beat_fire     = out_rsp_valid && out_rsp_ready;
    assign rsp_idx       = out_rsp_tag[LOG_R-1:0];
    assign rsp_utag      = out_rsp_tag[LOG_R +: TAG_WIDTH];
    assign in_rsp_valid  = rsp_full_q;
    assign in_rsp_data   = rsp_buf_q;
    assign in_rsp_tag    = rsp_tag_q;

    // Beat placement into the line buffer and line completion tracking.
    always_comb begin
        rsp_buf_d  = rsp_buf_q;
        rsp_cnt_d  = rsp_cnt_q;
        rsp_full_d = rsp_full_q;
        rsp_tag_d  = rsp_tag_q;
        if (in_rsp_ready) rsp_full_d = 1'b0;
        if (beat_fire) begin
            rsp_buf_d[rsp_idx] = out_rsp_data;
            rsp_tag_d          = rsp_utag;
            rsp_cnt_d          = rsp_cnt_q + idx_t'(1);
            if (rsp_cnt_q == idx_t'(RATIO - 1)) rsp_full_d = 1'b1;
        end
    end

    // Response counters and the full flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_cnt_q  <= '0;
            rsp_full_q <= 1'b0;
        end else begin
            rsp_cnt_q  <= rsp_cnt_d;
            rsp_full_q <= rsp_full_d;
        end
    end

    // Assembled line data and its tag.
    always_ff @(posedge clk) begin
        rsp_buf_q <= rsp_buf_d;
        rsp_tag_q <= rsp_tag_d;
    end

    // Every beat after the first of a line must echo that line's upper tag.
    a_same_line_tag: assert property (@(posedge clk) disable iff (reset)
        (beat_fire && rsp_cnt_q != '0) |-> (rsp_utag == rsp_tag_q));

endmodule
